// File: rtl/sched_epoch_ctrl.sv
// sched_epoch_ctrl: epoch sequencer around the 4x4 VOQ crossbar scheduler.
// Each epoch: snapshot VOQ occupancy, kick the scheduler, capture its grant,
// then drive per-ingress dequeue for a fixed transfer window. Packets still
// in flight at window end are remembered as busy and re-pinned next epoch.
// Optional feature macro: SCHED_CHECK_EN (grant consistency checking, sched_err).
module sched_epoch_ctrl #(
  parameter int unsigned EPOCH_LEN     = 16,
  parameter int unsigned SCHED_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] voq_empty_in,
  output logic        sched_en,
  output logic [15:0] voq_empty,
  output logic [3:0]  is_busy,
  output logic [7:0]  busy_voq_num,
  input  logic [3:0]  sched_sel_en,
  input  logic [7:0]  sched_sel,
  output logic [3:0]  deq_en,
  output logic [7:0]  deq_voq,
  input  logic [3:0]  pkt_last,
  output logic [15:0] epoch_cnt,
  output logic        sched_err,
  output logic        active
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SNAP = 3'd1,
    S_KICK = 3'd2,
    S_WAIT = 3'd3,
    S_XFER = 3'd4
  } state_e;

  localparam int unsigned CW = $clog2(EPOCH_LEN + SCHED_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] XFER_LAST = CW'(EPOCH_LEN - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(SCHED_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;            // enable as seen at this epoch's snapshot
  logic [15:0]   voq_empty_q, voq_empty_d;
  logic [3:0]    busy_q, busy_d;
  logic [7:0]    busy_voq_q, busy_voq_d;
  logic [3:0]    grant_en_q, grant_en_d;
  logic [7:0]    grant_sel_q, grant_sel_d;
  logic [3:0]    deq_en_q, deq_en_d;
  logic [7:0]    deq_voq_q, deq_voq_d;
  logic [15:0]   epoch_cnt_q, epoch_cnt_d;
  logic          sched_en_q, sched_en_d;
  logic          active_q, active_d;

  logic          grant_hit_s;
  logic          wait_done_s;
  logic          xfer_done_s;
  logic [3:0]    grant_en_s;
  logic [7:0]    grant_sel_s;

  assign grant_hit_s = |sched_sel_en;
  assign wait_done_s = (cnt_q == WAIT_LAST);
  assign xfer_done_s = (cnt_q == XFER_LAST);
  // On timeout the only legitimate "grant" is the set of packets already in flight.
  assign grant_en_s  = grant_hit_s ? sched_sel_en : busy_q;
  assign grant_sel_s = grant_hit_s ? sched_sel    : busy_voq_q;

`ifdef SCHED_CHECK_EN
  // Grant disagrees with the busy table, or two granted ingresses target one VOQ.
  function automatic logic grant_bad(input logic [3:0] busy, input logic [7:0] bvoq,
                                     input logic [3:0] gen,  input logic [7:0] gsel);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bad = bad | (busy[i] & (~gen[i] | (gsel[2*i+:2] != bvoq[2*i+:2])));
      for (int j = i + 1; j < 4; j++) begin
        bad = bad | (gen[i] & gen[j] & (gsel[2*i+:2] == gsel[2*j+:2]));
      end
    end
    return bad;
  endfunction

  logic sched_err_q, sched_err_d;

  // Sticky error flag, evaluated only when a real scheduler grant is latched.
  always_comb begin
    sched_err_d = sched_err_q;
    if ((state_q == S_WAIT) && grant_hit_s) begin
      sched_err_d = sched_err_q | grant_bad(busy_q, busy_voq_q, sched_sel_en, sched_sel);
    end else begin
      sched_err_d = sched_err_q;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sched_err_q <= 1'b0;
    end else begin
      sched_err_q <= sched_err_d;
    end
  end

  assign sched_err = sched_err_q;
`else
  assign sched_err = 1'b0;
`endif

  // Next-state and datapath updates for the epoch sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_d       = run_q;
    voq_empty_d = voq_empty_q;
    busy_d      = busy_q;
    busy_voq_d  = busy_voq_q;
    grant_en_d  = grant_en_q;
    grant_sel_d = grant_sel_q;
    deq_en_d    = deq_en_q;
    deq_voq_d   = deq_voq_q;
    epoch_cnt_d = epoch_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (enable || (|busy_q)) begin
          state_d = S_SNAP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SNAP: begin
        voq_empty_d = voq_empty_in;
        run_d       = enable;
        state_d     = S_KICK;
      end
      S_KICK: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (grant_hit_s || wait_done_s) begin
          grant_en_d  = grant_en_s;
          grant_sel_d = grant_sel_s;
          // Busy ingresses keep their stored VOQ regardless of what the scheduler says.
          for (int i = 0; i < 4; i++) begin
            if (busy_q[i]) begin
              deq_en_d[i]       = 1'b1;
              deq_voq_d[2*i+:2] = busy_voq_q[2*i+:2];
            end else if (grant_en_s[i] && run_q) begin
              deq_en_d[i]       = 1'b1;
              deq_voq_d[2*i+:2] = grant_sel_s[2*i+:2];
            end else begin
              deq_en_d[i]       = 1'b0;
            end
          end
          cnt_d   = '0;
          state_d = S_XFER;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = S_WAIT;
        end
      end
      S_XFER: begin
        deq_en_d = deq_en_q & ~pkt_last;
        if (xfer_done_s) begin
          busy_d = deq_en_q & ~pkt_last;
          for (int i = 0; i < 4; i++) begin
            busy_voq_d[2*i+:2] = busy_d[i] ? deq_voq_q[2*i+:2] : 2'd0;
          end
          deq_en_d    = 4'b0000;
          epoch_cnt_d = epoch_cnt_q + 16'd1;
          if (enable || (|busy_d)) begin
            state_d = S_SNAP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = S_XFER;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    sched_en_d = (state_d == S_KICK);
    active_d   = (state_d != S_IDLE);
  end

  // State and datapath registers; reset abandons any packet in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      run_q       <= 1'b0;
      voq_empty_q <= 16'h0000;
      busy_q      <= 4'b0000;
      busy_voq_q  <= 8'h00;
      grant_en_q  <= 4'b0000;
      grant_sel_q <= 8'h00;
      deq_en_q    <= 4'b0000;
      deq_voq_q   <= 8'h00;
      epoch_cnt_q <= 16'h0000;
      sched_en_q  <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_q       <= run_d;
      voq_empty_q <= voq_empty_d;
      busy_q      <= busy_d;
      busy_voq_q  <= busy_voq_d;
      grant_en_q  <= grant_en_d;
      grant_sel_q <= grant_sel_d;
      deq_en_q    <= deq_en_d;
      deq_voq_q   <= deq_voq_d;
      epoch_cnt_q <= epoch_cnt_d;
      sched_en_q  <= sched_en_d;
      active_q    <= active_d;
    end
  end

  assign sched_en     = sched_en_q;
  assign voq_empty    = voq_empty_q;
  assign is_busy      = busy_q;
  assign busy_voq_num = busy_voq_q;
  assign deq_en       = deq_en_q;
  assign deq_voq      = deq_voq_q;
  assign epoch_cnt    = epoch_cnt_q;
  assign active       = active_q;

endmodule

// File: tb/tb_sched_epoch_ctrl.sv
// Bench for sched_epoch_ctrl: table of whole-epoch vectors plus hand-written
// sequences for drain, grant-consistency error and reset mid-transfer.
module tb_sched_epoch_ctrl;

  localparam int EPOCH_LEN     = 16;
  localparam int SCHED_TIMEOUT = 8;
`ifdef SCHED_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] voq_empty_in;
  logic        sched_en;
  logic [15:0] voq_empty;
  logic [3:0]  is_busy;
  logic [7:0]  busy_voq_num;
  logic [3:0]  sched_sel_en;
  logic [7:0]  sched_sel;
  logic [3:0]  deq_en;
  logic [7:0]  deq_voq;
  logic [3:0]  pkt_last;
  logic [15:0] epoch_cnt;
  logic        sched_err;
  logic        active;

  sched_epoch_ctrl #(.EPOCH_LEN(EPOCH_LEN), .SCHED_TIMEOUT(SCHED_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .voq_empty_in(voq_empty_in),
    .sched_en(sched_en), .voq_empty(voq_empty), .is_busy(is_busy),
    .busy_voq_num(busy_voq_num), .sched_sel_en(sched_sel_en), .sched_sel(sched_sel),
    .deq_en(deq_en), .deq_voq(deq_voq), .pkt_last(pkt_last), .epoch_cnt(epoch_cnt),
    .sched_err(sched_err), .active(active)
  );

  always #5 clk = ~clk;

  // One epoch: grant at WAIT cycle 'delay' (0 = silent scheduler), pkt_last of
  // ingress i at XFER cycle last[5i+:5] (0 = never), expected results after.
  typedef struct {
    logic [15:0] voq_in;
    logic [3:0]  g_en;
    logic [7:0]  g_sel;
    int          delay;
    logic [19:0] last;
    logic [3:0]  exp_en;
    logic [7:0]  exp_voq;
    logic [3:0]  exp_busy;
    logic [7:0]  exp_bvoq;
  } vec_t;

  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;
  int   exp_epoch = 0;
  logic [3:0] exp_busy_cur = 4'b0000;
  logic [7:0] exp_bvoq_cur = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_epoch(input vec_t v);
    bit         found;
    int         d;
    logic [3:0] en_m;
    logic [3:0] pl;
    logic [7:0] m8;
    voq_empty_in = v.voq_in;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (sched_en) found = 1'b1;
    end
    chk("sched_en_seen", found, 1'b1);
    if (!found) return;
    chk("voq_empty_snap", voq_empty, v.voq_in);
    chk("busy_stable_kick", is_busy, exp_busy_cur);
    chk("busy_voq_stable_kick", busy_voq_num, exp_bvoq_cur);
    d = (v.delay == 0) ? SCHED_TIMEOUT : v.delay;
    for (int k = 1; k <= d; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("sched_en_single_pulse", sched_en, 1'b0);
        voq_empty_in = ~v.voq_in;
      end
      if (k == v.delay) begin
        sched_sel_en = v.g_en;
        sched_sel    = v.g_sel;
      end
    end
    en_m = v.exp_en;
    for (int c = 1; c <= EPOCH_LEN; c++) begin
      @(negedge clk);
      sched_sel_en = 4'b0000;
      sched_sel    = 8'h00;
      chk("deq_en", deq_en, en_m);
      if (c == 1) begin
        m8 = 8'h00;
        for (int i = 0; i < 4; i++) if (v.exp_en[i]) m8[2*i+:2] = 2'b11;
        chk("deq_voq", deq_voq & m8, v.exp_voq & m8);
        chk("voq_empty_frozen", voq_empty, v.voq_in);
        chk("busy_stable_xfer", is_busy, exp_busy_cur);
      end
      if (c == EPOCH_LEN) chk("epoch_cnt_before_end", epoch_cnt, exp_epoch[15:0]);
      pl = 4'b0000;
      for (int i = 0; i < 4; i++) if (v.last[5*i+:5] == 5'(c)) pl[i] = 1'b1;
      pkt_last = pl;
      en_m = en_m & ~pl;
    end
    @(negedge clk);
    pkt_last = 4'b0000;
    exp_epoch++;
    exp_busy_cur = v.exp_busy;
    exp_bvoq_cur = v.exp_bvoq;
    chk("deq_en_after_window", deq_en, 4'b0000);
    chk("is_busy_end", is_busy, v.exp_busy);
    chk("busy_voq_end", busy_voq_num, v.exp_bvoq);
    chk("epoch_cnt_end", epoch_cnt, exp_epoch[15:0]);
    chk("active_end", active, enable || (|v.exp_busy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bit   found;
    //                 voq_in    g_en     g_sel  dly  last (ing3..ing0)                   exp_en   exp_voq busy     bvoq
    vecs[0] = '{16'hFFFE, 4'b0001, 8'h00, 6, {5'd0,  5'd0, 5'd0, 5'd4},  4'b0001, 8'h00, 4'b0000, 8'h00};
    vecs[1] = '{16'hFF7F, 4'b0100, 8'h30, 3, {5'd0,  5'd0, 5'd0, 5'd0},  4'b0100, 8'h30, 4'b0100, 8'h30};
    vecs[2] = '{16'h0000, 4'b0111, 8'h39, 2, {5'd0,  5'd5, 5'd0, 5'd16}, 4'b0111, 8'h39, 4'b0010, 8'h08};
    vecs[3] = '{16'hA5A5, 4'b1010, 8'h08, 8, {5'd16, 5'd0, 5'd1, 5'd0},  4'b1010, 8'h08, 4'b0000, 8'h00};
    vecs[4] = '{16'hFFFF, 4'b0000, 8'h00, 0, {5'd0,  5'd0, 5'd0, 5'd0},  4'b0000, 8'h00, 4'b0000, 8'h00};
    vecs[5] = '{16'h0F0F, 4'b0001, 8'h00, 1, {5'd3,  5'd0, 5'd0, 5'd2},  4'b0001, 8'h00, 4'b0000, 8'h00};

    reset = 1'b1; enable = 1'b0; voq_empty_in = 16'h0000;
    sched_sel_en = 4'b0000; sched_sel = 8'h00; pkt_last = 4'b0000;
    repeat (3) @(negedge clk);
    chk("rst_deq_en", deq_en, 4'b0000);
    chk("rst_sched_en", sched_en, 1'b0);
    chk("rst_active", active, 1'b0);
    chk("rst_epoch_cnt", epoch_cnt, 16'h0000);
    chk("rst_is_busy", is_busy, 4'b0000);
    chk("rst_voq_empty", voq_empty, 16'h0000);
    chk("rst_sched_err", sched_err, 1'b0);
    reset = 1'b0;
    enable = 1'b1;

    for (int n = 0; n < 6; n++) run_epoch(vecs[n]);

    // Drain: ingress 1 left in flight, then enable drops; new grant for ingress 0 is masked.
    v = '{16'h1234, 4'b0010, 8'h04, 4, {5'd0, 5'd0, 5'd0, 5'd0}, 4'b0010, 8'h04, 4'b0010, 8'h04};
    run_epoch(v);
    enable = 1'b0;
    v = '{16'h5678, 4'b0011, 8'h04, 2, {5'd0, 5'd0, 5'd3, 5'd0}, 4'b0010, 8'h04, 4'b0000, 8'h00};
    run_epoch(v);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("drain_idle_active", active, 1'b0);
      chk("drain_idle_sched_en", sched_en, 1'b0);
    end

    // Busy ingress 3 on VOQ 1, then scheduler tries to move it to VOQ 2.
    enable = 1'b1;
    v = '{16'h0000, 4'b1000, 8'h40, 5, {5'd0, 5'd0, 5'd0, 5'd0}, 4'b1000, 8'h40, 4'b1000, 8'h40};
    run_epoch(v);
    chk("sched_err_clean", sched_err, 1'b0);
    v = '{16'h0000, 4'b1000, 8'h80, 2, {5'd2, 5'd0, 5'd0, 5'd0}, 4'b1000, 8'h40, 4'b0000, 8'h00};
    run_epoch(v);
    chk("sched_err_set", sched_err, EXP_ERR);

    // Reset in the middle of a transfer window with two ingresses dequeuing.
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (sched_en) found = 1'b1;
    end
    chk("rst_seq_sched_en_seen", found, 1'b1);
    @(negedge clk);
    sched_sel_en = 4'b0011; sched_sel = 8'h09;
    @(negedge clk);
    sched_sel_en = 4'b0000; sched_sel = 8'h00;
    chk("rst_seq_deq_en_c1", deq_en, 4'b0011);
    chk("sched_err_sticky", sched_err, EXP_ERR);
    repeat (2) @(negedge clk);
    chk("rst_seq_deq_en_c3", deq_en, 4'b0011);
    chk("rst_seq_deq_voq", deq_voq[3:0], 4'h9);
    reset = 1'b1;
    enable = 1'b0;
    #1;
    chk("midrst_deq_en", deq_en, 4'b0000);
    chk("midrst_is_busy", is_busy, 4'b0000);
    chk("midrst_active", active, 1'b0);
    chk("midrst_epoch_cnt", epoch_cnt, 16'h0000);
    chk("midrst_sched_err", sched_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_deq_en", deq_en, 4'b0000);
      chk("post_rst_active", active, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
